// File: rtl/day021_fifo_parametric.sv
// rtl/day021_fifo_parametric.sv - parametric synchronous FIFO with registered or fall-through read
module day021_fifo_parametric #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk_i,
  input  logic                     n_rst_i,
  input  logic                     flush_i,
  input  logic                     we_i,
  input  logic [DATA_W-1:0]        data_in_i,
  input  logic                     re_i,
  output logic [DATA_W-1:0]        data_out_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_L    = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_L    = PTR_W'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] head;
  logic              wr_ok;
  logic              rd_ok;

  // Pointer difference wraps modulo 2*DEPTH, so the extra MSB tells full from empty.
  assign count_o        = wr_ptr - rd_ptr;
  assign empty_o        = (count_o == '0);
  assign full_o         = (count_o == DEPTH_L);
  assign almost_full_o  = (count_o >= AF_L);
  assign almost_empty_o = (count_o <= AE_L);

  // Flush overrides both requests; a full FIFO refuses the write even when a read frees a slot.
  assign wr_ok = n_rst_i && we_i && !full_o && !flush_i;
  assign rd_ok = n_rst_i && re_i && !empty_o && !flush_i;

  assign head = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are not reset, only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= data_in_i;
    end
  end

  // Write and read pointers, cleared by reset or flush.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky error flags: set by refused requests, cleared only by flush or reset.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (we_i && full_o)  overflow_o  <= 1'b1;
      if (re_i && empty_o) underflow_o <= 1'b1;
    end
  end

  // Output word register: in registered mode it captures the popped word; in fall-through
  // mode it remembers the last visible head so the output holds once the FIFO drains or
  // is flushed.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      dout_q <= '0;
    end else if (FWFT != 0) begin
      if (rd_ok || (flush_i && !empty_o)) dout_q <= head;
    end else begin
      if (rd_ok) dout_q <= head;
    end
  end

  assign data_out_o = ((FWFT != 0) && !empty_o) ? head : dout_q;

endmodule

// File: tb/tb_day021_fifo_parametric.sv
// tb/tb_day021_fifo_parametric.sv - directed vector bench for day021_fifo_parametric
module tb_day021_fifo_parametric;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        flush = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] dout0, dout1;
  logic        full0, empty0, af0, ae0, ov0, un0;
  logic        full1, empty1, af1, ae1, ov1, un1;
  logic [4:0]  count0, count1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  day021_fifo_parametric #(.DATA_W(16), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_reg (
    .clk_i(clk), .n_rst_i(n_rst), .flush_i(flush), .we_i(we), .data_in_i(din), .re_i(re),
    .data_out_o(dout0), .full_o(full0), .empty_o(empty0), .almost_full_o(af0),
    .almost_empty_o(ae0), .count_o(count0), .overflow_o(ov0), .underflow_o(un0)
  );

  day021_fifo_parametric #(.DATA_W(16), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk_i(clk), .n_rst_i(n_rst), .flush_i(flush), .we_i(we), .data_in_i(din), .re_i(re),
    .data_out_o(dout1), .full_o(full1), .empty_o(empty1), .almost_full_o(af1),
    .almost_empty_o(ae1), .count_o(count1), .overflow_o(ov1), .underflow_o(un1)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic        flush;
    logic [15:0] din;
    int          count;
    logic        empty;
    logic        full;
    logic        af;
    logic        ae;
    logic        ov;
    logic        un;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic f, input logic [15:0] d);
    @(negedge clk);
    we = w; re = r; flush = f; din = d;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic f, input logic [15:0] d,
                              input int c, input logic ov, input logic un, input logic [15:0] q);
    vec_t v;
    v.we = w; v.re = r; v.flush = f; v.din = d; v.count = c;
    v.empty = (c == 0); v.full = (c == 16); v.af = (c >= 14); v.ae = (c <= 2);
    v.ov = ov; v.un = un; v.dout = q;
    return v;
  endfunction

  initial begin
    // Fill: 16 writes of 1..16, output register untouched.
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(1, 0, 0, 16'(k), k, 0, 0, 16'h0000));
    // Write while full is refused.
    vecs.push_back(mk(1, 0, 0, 16'hDEAD, 16, 1, 0, 16'h0000));
    // Simultaneous write/read while full: only the read happens.
    vecs.push_back(mk(1, 1, 0, 16'hBEEF, 15, 1, 0, 16'h0001));
    // Drain the rest in order.
    for (int j = 2; j <= 16; j++) vecs.push_back(mk(0, 1, 0, 16'h0, 16 - j, 1, 0, 16'(j)));
    // Read while empty, then flush.
    vecs.push_back(mk(0, 1, 0, 16'h0, 0, 1, 1, 16'h0010));
    vecs.push_back(mk(0, 0, 1, 16'h0, 0, 0, 0, 16'h0010));

    // Reset state.
    #12;
    check("rst_count", 32'(count0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_ae", 32'(ae0), 32'd1);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_af", 32'(af0), 32'd0);
    check("rst_flags", 32'({ov0, un0}), 32'd0);
    check("rst_dout", 32'(dout0), 32'd0);
    check("rst_dout_fwft", 32'(dout1), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].re, vecs[i].flush, vecs[i].din);
      check($sformatf("v%0d_count", i), 32'(count0), 32'(vecs[i].count));
      check($sformatf("v%0d_empty", i), 32'(empty0), 32'(vecs[i].empty));
      check($sformatf("v%0d_full", i), 32'(full0), 32'(vecs[i].full));
      check($sformatf("v%0d_af", i), 32'(af0), 32'(vecs[i].af));
      check($sformatf("v%0d_ae", i), 32'(ae0), 32'(vecs[i].ae));
      check($sformatf("v%0d_ov", i), 32'(ov0), 32'(vecs[i].ov));
      check($sformatf("v%0d_un", i), 32'(un0), 32'(vecs[i].un));
      check($sformatf("v%0d_dout", i), 32'(dout0), 32'(vecs[i].dout));
    end

    // Streaming at count 1 across several pointer wraps.
    step(1, 0, 0, 16'h0100);
    check("stream_pre_count", 32'(count0), 32'd1);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 16'(16'h0101 + i));
      check($sformatf("stream%0d_count", i), 32'(count0), 32'd1);
      check($sformatf("stream%0d_dout", i), 32'(dout0), 32'(16'h0100 + i));
      check($sformatf("stream%0d_fwft", i), 32'(dout1), 32'(16'h0101 + i));
    end
    step(0, 1, 0, 16'h0);
    check("stream_last_dout", 32'(dout0), 32'h0128);
    check("stream_last_empty", 32'(empty0), 32'd1);
    check("stream_flags", 32'({ov0, un0}), 32'd0);

    // Fall-through: written word visible without a read, holds after the pop.
    step(0, 0, 1, 16'h0);
    step(1, 0, 0, 16'hA5A5);
    check("fwft_dout", 32'(dout1), 32'hA5A5);
    check("fwft_not_empty", 32'(empty1), 32'd0);
    check("fwft_reg_dout_held", 32'(dout0), 32'h0128);
    step(0, 1, 0, 16'h0);
    check("fwft_pop_empty", 32'(empty1), 32'd1);
    check("fwft_pop_hold", 32'(dout1), 32'hA5A5);

    // Asynchronous reset mid-cycle with 7 words stored.
    for (int i = 0; i < 7; i++) step(1, 0, 0, 16'(16'h0200 + i));
    check("pre_rst_count", 32'(count0), 32'd7);
    #3;
    n_rst = 1'b0;
    #1;
    check("async_rst_count", 32'(count0), 32'd0);
    check("async_rst_empty", 32'(empty0), 32'd1);
    check("async_rst_dout", 32'(dout0), 32'd0);
    we = 1'b0; re = 1'b0; flush = 1'b0;
    n_rst = 1'b1;
    step(1, 0, 0, 16'h3333);
    check("post_rst_count", 32'(count0), 32'd1);
    check("post_rst_fwft", 32'(dout1), 32'h3333);
    step(0, 1, 0, 16'h0);
    check("post_rst_dout", 32'(dout0), 32'h3333);
    check("post_rst_empty", 32'(empty0), 32'd1);
    step(0, 0, 0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/day021_fifo_parametric.md
DAY021_FIFO_PARAMETRIC -- requirements
Module: day021_fifo_parametric

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 16, storage words (power of 2, >=4).
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-2, almost-full level (1..DEPTH).
REQ-004 The block SHALL have parameter AE_THRESH, default 2, almost-empty level (0..DEPTH-1).
REQ-005 The block SHALL have parameter FWFT, default 0, read mode (0 = registered read, 1 = first-word-fall-through).
REQ-006 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port n_rst_i, input, 1, reset, asynchronous and active-low.
REQ-008 The block SHALL have port flush_i, input, 1, synchronous clear of FIFO contents and error flags.
REQ-009 The block SHALL have port we_i, input, 1, write request.
REQ-010 The block SHALL have port data_in_i, input, DATA_W, write data.
REQ-011 The block SHALL have port re_i, input, 1, read request.
REQ-012 The block SHALL have port data_out_o, output, DATA_W, read data.
REQ-013 The block SHALL have ports full_o, empty_o, almost_full_o and almost_empty_o, each output, 1, status flags.
REQ-014 The block SHALL have port count_o, output, $clog2(DEPTH)+1, words currently stored.
REQ-015 The block SHALL have ports overflow_o and underflow_o, each output, 1, sticky error flags.

Function
REQ-016 Read and write pointers SHALL each be $clog2(DEPTH)+1 bits, with the MSB as wrap bit; address = lower bits, wrapping DEPTH-1 -> 0.
REQ-017 A write SHALL be accepted iff we_i=1 and full_o=0; data_in_i is stored at the write address and the write pointer increments.
REQ-018 A read SHALL be accepted iff re_i=1 and empty_o=0; the read pointer increments.
REQ-019 Accepted read and write in the same cycle SHALL both complete, leaving count_o unchanged, including when count_o=1.
REQ-020 When full_o=1, simultaneous we_i and re_i SHALL accept only the read (the write is refused and sets overflow_o).
REQ-021 count_o SHALL equal wr_ptr - rd_ptr (modulo 2*DEPTH) and be derived from registered pointers, valid from the edge after each update.
REQ-022 Flags: empty_o = (count_o==0), full_o = (count_o==DEPTH), almost_full_o = (count_o>=AF_THRESH), almost_empty_o = (count_o<=AE_THRESH).
REQ-023 FWFT=0: on an accepted read, data_out_o SHALL register the head word at that edge (1-cycle latency); otherwise it holds its value.
REQ-024 FWFT=1: data_out_o SHALL show the head word whenever empty_o=0 with no extra latency; an accepted read pops it. When empty, it holds the last word.
REQ-025 A refused write (we_i=1, full_o=1) SHALL set overflow_o=1 and leave memory and pointers unchanged.
REQ-026 A refused read (re_i=1, empty_o=1) SHALL set underflow_o=1 and leave data_out_o and pointers unchanged.
REQ-027 overflow_o and underflow_o SHALL stay at 1 until flush_i or reset.
REQ-028 flush_i=1 SHALL take priority over we_i and re_i in the same cycle: pointers <- 0 and error flags <- 0; memory and data_out_o are unchanged.

Reset
REQ-029 While n_rst_i=0, pointers, count_o, data_out_o, overflow_o and underflow_o SHALL be forced to 0 immediately, without a clock.
REQ-030 During and after reset: empty_o=1, almost_empty_o=1, full_o=0, and almost_full_o=0 (given AF_THRESH>=1).
REQ-031 Reset asserted mid-operation SHALL discard all stored words; memory contents need not be reset.
REQ-032 After n_rst_i deasserts, the first rising edge SHALL process requests normally.

Verification (DATA_W=16, DEPTH=16, AF_THRESH=14, AE_THRESH=2)
REQ-033 Reset, then write 0x0001..0x0010 -> count_o steps 1..16; almost_empty_o clears at count 3; almost_full_o sets at 14; full_o sets at 16; overflow_o=0.
REQ-034 17th write of 0xDEAD when full -> overflow_o=1 and count_o=16; 16 reads return 0x0001..0x0010 in order, with 0xDEAD absent and empty_o=1 at the end.
REQ-035 Read while empty -> underflow_o=1 and data_out_o holds 0x0010; flush_i -> both sticky flags 0 and count_o=0.
REQ-036 Continuous simultaneous we_i/re_i for 40 cycles from count_o=1 -> count_o stays 1, pointers wrap, and data is preserved in order.
REQ-037 FWFT=1: write 0xA5A5 into an empty FIFO -> data_out_o=0xA5A5 on the edge after the write with no read; pop -> empty_o=1.
REQ-038 Assert n_rst_i=0 mid-clock at count_o=7 -> count_o=0 and empty_o=1 before the next edge; the next write/read returns the new data.
